// File: rtl/trig_prescale_burst.sv
// Trigger conditioner for the fast gate/delay generator input.
// Synchronises an asynchronous trigger, detects rising edges, divides the edge
// rate by a programmable factor and emits fixed-width pulses. A pulse train can
// optionally stop after a programmed burst. Out always returns low between
// pulses so the downstream stage re-arms on every event.
module trig_prescale_burst #(
  parameter int unsigned N           = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_trig_in,
  input  logic         i_enable,
  input  logic         i_arm,
  input  logic [N-1:0] i_divide,
  input  logic [N-1:0] i_width,
  input  logic [N-1:0] i_burst,
  output logic         o_out,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_overrun,
  output logic [N-1:0] o_pulse_cnt
);

  localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StPulse,
    StDone
  } state_e;

  // Synchroniser and edge detector
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;
  logic                   r_rise;
  logic                   w_sync_out;
  logic                   w_rise;

  // Control state
  state_e                 r_state;
  logic                   r_out;
  logic                   r_overrun;
  logic                   r_pend;
  logic [N-1:0]           r_pulse_cnt;
  logic [N-1:0]           r_pre_cnt;
  logic [N-1:0]           r_wid_cnt;

  // Parameters captured at arm time, stored minus one
  logic [N-1:0]           r_div_m1;
  logic [N-1:0]           r_wid_m1;
  logic [N-1:0]           r_burst;

  // Derived combinational terms
  logic [N-1:0]           w_div_m1;
  logic [N-1:0]           w_wid_m1;
  logic [N-1:0]           w_cnt_inc;
  logic                   w_pre_hit;
  logic                   w_wid_last;
  logic                   w_burst_end;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_rise     = w_sync_out & ~r_edge;

  // Zero on Divide/Width is treated as one, so the minus-one form saturates at 0.
  assign w_div_m1 = (i_divide == '0) ? '0 : i_divide - One;
  assign w_wid_m1 = (i_width == '0) ? '0 : i_width - One;

  assign w_pre_hit   = (r_pre_cnt == r_div_m1);
  assign w_wid_last  = (r_wid_cnt == '0);
  assign w_cnt_inc   = r_pulse_cnt + One;
  assign w_burst_end = (r_burst != '0) && (w_cnt_inc == r_burst);

  // Shift the trigger through the synchroniser, then register the detected edge.
  // The rise flag is registered so the FSM only ever sees a clean one-cycle strobe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_edge <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_trig_in};
      r_edge <= w_sync_out;
      r_rise <= w_rise;
    end
  end

  // Arm/prescale/pulse/burst state machine with registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_out       <= 1'b0;
      r_overrun   <= 1'b0;
      r_pend      <= 1'b0;
      r_pulse_cnt <= '0;
      r_pre_cnt   <= '0;
      r_wid_cnt   <= '0;
      r_div_m1    <= '0;
      r_wid_m1    <= '0;
      r_burst     <= '0;
    end else if (!i_enable) begin
      // Abort: Overrun and PulseCnt are kept for inspection.
      r_state   <= StIdle;
      r_out     <= 1'b0;
      r_pend    <= 1'b0;
      r_pre_cnt <= '0;
      r_wid_cnt <= '0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (i_arm) begin
            r_state     <= StArmed;
            r_pre_cnt   <= '0;
            r_pulse_cnt <= '0;
            r_overrun   <= 1'b0;
            r_pend      <= 1'b0;
            r_div_m1    <= w_div_m1;
            r_wid_m1    <= w_wid_m1;
            r_burst     <= i_burst;
          end
        end

        StArmed: begin
          if (r_pend) begin
            // Expiry that landed on the previous pulse's final cycle.
            r_pend    <= 1'b0;
            r_out     <= 1'b1;
            r_wid_cnt <= r_wid_m1;
            r_state   <= StPulse;
          end else if (r_rise) begin
            if (w_pre_hit) begin
              r_pre_cnt <= '0;
              r_out     <= 1'b1;
              r_wid_cnt <= r_wid_m1;
              r_state   <= StPulse;
            end else begin
              r_pre_cnt <= r_pre_cnt + One;
            end
          end
        end

        StPulse: begin
          // The prescaler keeps counting while a pulse is in flight.
          if (r_rise) begin
            if (w_pre_hit) begin
              r_pre_cnt <= '0;
              if (w_wid_last) begin
                // Defer to ARMED; a low gap cycle is guaranteed. Dropped if burst ends.
                r_pend <= ~w_burst_end;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_pre_cnt <= r_pre_cnt + One;
            end
          end

          if (w_wid_last) begin
            r_out       <= 1'b0;
            r_pulse_cnt <= w_cnt_inc;
            r_state     <= w_burst_end ? StDone : StArmed;
          end else begin
            r_wid_cnt <= r_wid_cnt - One;
          end
        end

        default: begin
          r_state <= StIdle;
          r_out   <= 1'b0;
        end
      endcase
    end
  end

  assign o_out       = r_out;
  assign o_busy      = (r_state == StArmed) || (r_state == StPulse);
  assign o_done      = (r_state == StDone);
  assign o_overrun   = r_overrun;
  assign o_pulse_cnt = r_pulse_cnt;

endmodule

// File: doc/trig_prescale_burst.md
Name: trig_prescale_burst

Overview:
- Front-end trigger conditioner that drives the Inp of the fast gate/delay generator.
- Synchronises an asynchronous external trigger and detects its rising edges.
- Divides the edge rate by a programmable factor and emits fixed-width, clean pulses.
- Optionally stops after a programmed burst of pulses.
- Output always returns low between pulses, so the downstream gate/delay stage re-arms on every event.

Parameters:
- N, 32, width of Divide/Width/Burst inputs and of internal counters.
- SYNC_STAGES, 2, flip-flops in the TrigIn synchroniser (legal values ≥2).

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst_n  in  1  synchronous, active-low reset.
- TrigIn  in  1  asynchronous external trigger.
- Enable  in  1  level; 0 forces IDLE.
- Arm  in  1  single-cycle start/re-arm request.
- Divide  in  N  prescale factor; 0 treated as 1.
- Width  in  N  output pulse width in Clk cycles; 0 treated as 1.
- Burst  in  N  pulses per arm; 0 = continuous.
- Out  out  1  conditioned trigger pulse, registered.
- Busy  out  1  high in ARMED or PULSE.
- Done  out  1  high in DONE.
- Overrun  out  1  sticky; a prescaled event was dropped.
- PulseCnt  out  N  pulses emitted since last arm; wraps modulo 2^N.

Behaviour:
- Reset (Rst_n=0 at a Clk edge): state=IDLE; Out, Done, Overrun = 0; PulseCnt, prescale count and width count = 0; synchroniser and edge registers = 0.
- Edge detect:
  - TrigIn passes through SYNC_STAGES flops, then one edge register.
  - rise = sync_out & ~edge_reg.
  - With SYNC_STAGES=2, rise is high during the 3rd Clk edge after TrigIn goes high, provided setup is met.
  - A rise lasts exactly one cycle per TrigIn low→high transition.
- Div_eff = max(Divide,1) and Wid_eff = max(Width,1). These and Burst are latched at Arm; later changes have no effect until the next Arm.
- Enable=0: next state IDLE and Out=0 on the next edge from any state. Counts are cleared; Overrun and PulseCnt hold.
- IDLE:
  - Arm & Enable -> ARMED.
  - Clears prescale count, PulseCnt and Overrun; latches parameters.
  - Arm in ARMED or PULSE is ignored.
- ARMED, on rise:
  - If pre_cnt == Div_eff-1: pre_cnt←0, Out←1, wid_cnt←Wid_eff-1, go to PULSE.
  - Otherwise pre_cnt←pre_cnt+1.
  - Out rises on the edge after the rise cycle, giving a latency of 4 Clk from TrigIn with SYNC_STAGES=2.
- PULSE:
  - Out stays 1; wid_cnt decrements each cycle.
  - When wid_cnt==0: Out←0 and PulseCnt←PulseCnt+1. Then go to DONE if Burst≠0 and PulseCnt+1==Burst, otherwise go to ARMED.
  - Out is therefore high for exactly Wid_eff cycles.
  - Rises in PULSE still advance pre_cnt.
  - A prescaler expiry in PULSE sets Overrun←1 and pre_cnt←0. That event produces no pulse and is not counted.
- Low gap: Out is low for ≥1 cycle between pulses. A rise on the same cycle PULSE exits is counted by the prescaler. If that rise completes the divide, the new pulse starts from ARMED one cycle later; this case is not an overrun.
- DONE:
  - Out=0, Done=1; TrigIn edges are ignored.
  - Arm & Enable -> ARMED, with the same clears and latching as from IDLE.
- Outputs:
  - Busy and Done are decoded from the state register; no extra latency.
  - PulseCnt wraps past 2^N-1 with no flag.
- Reset during PULSE: Out drops on that edge and all state returns to reset values.

Test Plan:
- Reset/idle: Rst_n=0 for 3 cycles with TrigIn toggling, then Rst_n=1 with no Arm -> Out=0, Busy=0, Done=0, PulseCnt=0 throughout.
- Basic latency: Divide=1, Width=4, Burst=0, Arm, one TrigIn rise -> Out high exactly 4 cycles starting 4 Clk after the TrigIn edge; PulseCnt=1.
- Prescale and burst: Divide=3, Width=2, Burst=2, 9 rises spaced 10 cycles apart -> pulses after rises 3 and 6 only; Done=1 after the second pulse; rise 9 ignored; PulseCnt=2.
- Zero handling: Divide=0, Width=0 -> every rise yields a 1-cycle Out pulse; a re-Arm from DONE clears PulseCnt.
- Overrun: Divide=2, Width=20, rises every 3 cycles -> Overrun=1 on the first expiry inside PULSE; dropped pulse not counted; Out goes low for ≥1 cycle between pulses.
- Abort: Enable dropped mid-PULSE -> Out=0 on the next edge, state IDLE; then Rst_n=0 -> Overrun and PulseCnt cleared.
